// File: rtl/board_refresh_ctrl.sv
// board_refresh_ctrl: removes full rows from the board RAM bottom-up, compacts, zero-fills the top, scores.
// Define BOARD_REFRESH_SKIP_SAME_ROW_EN to suppress rewriting a row onto itself.
module board_refresh_ctrl #(
  parameter int W       = 10,
  parameter int H       = 20,
  parameter int AW      = 5,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               refresh,
  output logic               busy,
  output logic               refresh_done,
  output logic               row_ren,
  output logic [AW-1:0]      row_raddr,
  input  logic [W-1:0]       row_rdata,
  output logic               row_wen,
  output logic [AW-1:0]      row_waddr,
  output logic [W-1:0]       row_wdata,
  output logic [AW-1:0]      lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic               top_occupied
);
  typedef enum logic [2:0] {IDLE, READ, CHECK, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, fill_q, fill_d, lines_q, lines_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic top_q, top_d;
  logic full, wr_row;
  logic [3:0] pts;
  logic [SCORE_W:0] sum;
  assign full = &row_rdata;
`ifdef BOARD_REFRESH_SKIP_SAME_ROW_EN
  assign wr_row = !full && (src_q != dst_q);
`else
  assign wr_row = !full;
`endif
  assign pts = cnt_q >= AW'(4) ? 4'd8 : cnt_q == AW'(3) ? 4'd5 : cnt_q == AW'(2) ? 4'd3 :
               cnt_q == AW'(1) ? 4'd1 : 4'd0;
  assign sum = {1'b0, score_q} + {{(SCORE_W-3){1'b0}}, pts};
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    lines_d      = lines_q;
    score_d      = score_q;
    top_d        = top_q;
    row_ren      = 1'b0;
    row_raddr    = src_q;
    row_wen      = 1'b0;
    row_waddr    = dst_q;
    row_wdata    = state_q == CHECK ? row_rdata : '0;
    refresh_done = 1'b0;
    case (state_q)
      IDLE: if (refresh) begin
        src_d   = AW'(H-1);
        dst_d   = AW'(H-1);
        cnt_d   = '0;
        fill_d  = '0;
        top_d   = 1'b0;
        state_d = READ;
      end
      READ: begin
        row_ren = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (full) cnt_d = cnt_q + 1'b1;
        else begin
          row_wen = wr_row;
          dst_d   = dst_q - 1'b1;
          if (dst_q == '0 && |row_rdata) top_d = 1'b1;
        end
        if (src_q == '0) state_d = cnt_d != '0 ? FILL : DONE;
        else begin
          src_d   = src_q - 1'b1;
          state_d = READ;
        end
      end
      FILL: begin
        row_wen   = 1'b1;
        row_waddr = fill_q;
        fill_d    = fill_q + 1'b1;
        if (fill_q == cnt_q - 1'b1) state_d = DONE;
      end
      DONE: begin
        refresh_done = 1'b1;
        lines_d      = cnt_q;
        score_d      = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      lines_q <= '0;
      score_q <= '0;
      top_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      lines_q <= lines_d;
      score_q <= score_d;
      top_q   <= top_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign lines_cleared = lines_q;
  assign score         = score_q;
  assign top_occupied  = top_q;
endmodule

// File: tb/tb_board_refresh_ctrl.sv
// tb_board_refresh_ctrl: directed checks of board compaction, scoring, latency and reset behaviour.
module tb_board_refresh_ctrl;
  localparam int W = 10, H = 20, AW = 5, SW = 16;
  logic clk = 1'b0, rstn = 1'b1, refresh = 1'b0;
  logic busy, refresh_done, row_ren, row_wen, top_occupied;
  logic [AW-1:0] row_raddr, row_waddr, lines_cleared;
  logic [W-1:0] row_rdata, row_wdata;
  logic [SW-1:0] score;
  logic [W-1:0] mem [H];
  logic [W-1:0] img [H];
  logic ld_en = 1'b0, clr = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0] ld_data = '0;
  int wen_cnt = 0, acc_cnt = 0, done_cnt = 0;
  int n_assert = 0, n_fail = 0, lat, nz;
  always #5 clk = ~clk;
  board_refresh_ctrl #(.W(W), .H(H), .AW(AW), .SCORE_W(SW)) dut (
    .clk(clk), .rstn(rstn), .refresh(refresh), .busy(busy), .refresh_done(refresh_done),
    .row_ren(row_ren), .row_raddr(row_raddr), .row_rdata(row_rdata), .row_wen(row_wen),
    .row_waddr(row_waddr), .row_wdata(row_wdata), .lines_cleared(lines_cleared),
    .score(score), .top_occupied(top_occupied)
  );
  always @(posedge clk) begin
    if (row_ren) row_rdata <= mem[row_raddr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (row_wen) mem[row_waddr] <= row_wdata;
  end
  always @(posedge clk) begin
    if (clr) begin
      wen_cnt  <= 0;
      acc_cnt  <= 0;
      done_cnt <= 0;
    end else begin
      wen_cnt  <= wen_cnt + int'(row_wen);
      acc_cnt  <= acc_cnt + int'(row_wen | row_ren);
      done_cnt <= done_cnt + int'(refresh_done);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_img();
    for (int i = 0; i < H; i++) img[i] = '0;
  endtask
  task automatic load();
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = img[i];
    end
    @(negedge clk); ld_en = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask
  task automatic run(output int l);
    @(negedge clk); refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    l = 0;
    while (l < 200) begin
      @(negedge clk); l++;
      if (refresh_done) break;
    end
    @(negedge clk);
  endtask
  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", refresh_done, 0);
    check("rst_ren", row_ren, 0);
    check("rst_wen", row_wen, 0);
    check("rst_score", score, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_top", top_occupied, 0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_access", acc_cnt, 0);
    // two bottom rows full
    clear_img(); img[19] = 10'h3FF; img[18] = 10'h3FF;
    load(); run(lat);
    check("a_lat", lat, 43);
    check("a_lines", lines_cleared, 2);
    check("a_score", score, 3);
    check("a_top", top_occupied, 0);
    check("a_row19", mem[19], 0);
    check("a_row1", mem[1], 0);
    check("a_row0", mem[0], 0);
    check("a_wen", wen_cnt, 20);
    check("a_busy", busy, 0);
    clear_img(); img[19] = 10'h3FF; img[18] = 10'h155; img[0] = 10'h001;
    load(); run(lat);
    check("b_lat", lat, 42);
    check("b_row19", mem[19], 10'h155);
    check("b_row1", mem[1], 10'h001);
    check("b_row0", mem[0], 0);
    check("b_lines", lines_cleared, 1);
    check("b_top", top_occupied, 0);
    check("b_score", score, 4);
    clear_img(); img[0] = 10'h200;
    load(); run(lat);
    check("c_lat", lat, 41);
    check("c_lines", lines_cleared, 0);
    check("c_top", top_occupied, 1);
    check("c_score", score, 4);
    check("c_row0", mem[0], 10'h200);
`ifdef BOARD_REFRESH_SKIP_SAME_ROW_EN
    check("c_wen", wen_cnt, 0);
`else
    check("c_wen", wen_cnt, 20);
`endif
    @(negedge clk);
    force dut.score_q = 16'hFFFC;
    #1 release dut.score_q;
    check("sat_preload", score, 16'hFFFC);
    clear_img(); for (int i = 16; i < H; i++) img[i] = 10'h3FF;
    load(); run(lat);
    check("sat_lat", lat, 45);
    check("sat_lines", lines_cleared, 4);
    check("sat_score", score, 16'hFFFF);
    check("sat_top", top_occupied, 0);
    // second refresh while busy must be dropped
    clear_img(); img[19] = 10'h3FF;
    load();
    @(negedge clk); refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    repeat (5) @(negedge clk);
    check("rr_busy", busy, 1);
    refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    repeat (90) @(negedge clk);
    check("rr_done_cnt", done_cnt, 1);
    check("rr_lines", lines_cleared, 1);
    check("rr_score", score, 16'hFFFF);
    check("rr_busy_end", busy, 0);
    clear_img(); img[10] = 10'h0F0;
    load();
    @(negedge clk); refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
    @(negedge clk);
    check("mr_read", row_ren, 1);
    @(negedge clk);
    check("mr_check_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_wen", row_wen, 0);
    check("mr_done", refresh_done, 0);
    check("mr_score", score, 0);
    @(negedge clk); rstn = 1'b1;
    repeat (60) @(negedge clk);
    check("mr_done_cnt", done_cnt, 0);
    check("mr_idle", busy, 0);
    for (int i = 0; i < H; i++) img[i] = 10'h3FF;
    load(); run(lat);
    check("f_lat", lat, 61);
    check("f_lines", lines_cleared, 20);
    check("f_score", score, 8);
    check("f_top", top_occupied, 0);
    check("f_wen", wen_cnt, 20);
    nz = 0;
    for (int i = 0; i < H; i++) if (mem[i] != '0) nz++;
    check("f_nonzero_rows", nz, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
